// File: rtl/mini16_uart_arb_pkg.sv
// mini16_uart_arb_pkg
// Shared definitions for the mini16 UART transmit arbiter: the arbiter state
// encoding and a clog2 helper that never returns zero, so index ports stay at
// least one bit wide.
package mini16_uart_arb_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } arb_state_t;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mini16_rr_pick.sv
// mini16_rr_pick
// Combinational rotate-priority encoder. Starting at i_ptr and searching
// upward with wrap at N-1, returns the first set request bit.
// Ports:
//   i_req    [N-1:0]   request vector
//   i_ptr    [PW-1:0]  highest-priority index (must be < N)
//   o_winner [PW-1:0]  index of the selected request
//   o_found            at least one request bit set
module mini16_rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [PW-1:0] o_winner,
  output logic          o_found
);

  // One spare bit so ptr + offset cannot overflow before the wrap compare.
  logic [PW:0] w_sum;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    o_found  = 1'b0;
    o_winner = '0;
    w_sum    = '0;
    // Walk from the farthest offset down to 0: the nearest hit is written last.
    for (int k = N - 1; k >= 0; k--) begin
      w_sum = {1'b0, i_ptr} + (PW + 1)'(k);
      if (w_sum >= (PW + 1)'(N)) w_sum = w_sum - (PW + 1)'(N);
      if (i_req[w_sum[PW-1:0]]) begin
        o_found  = 1'b1;
        o_winner = w_sum[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/mini16_uart_tx_arbiter.sv
// mini16_uart_tx_arbiter
// Shares one UART transmitter among CORES requesters with byte-level
// round-robin arbitration. A granted byte is latched, a one-cycle start pulse
// is sent to the UART, and the grant is returned once uart_busy falls again.
// A start that never sees uart_busy within BUSY_TIMEOUT cycles is abandoned
// and flagged in the sticky timeout_err.
// Optional feature: define UART_ARB_LOCK_EN to let the current owner keep
// the grant across bytes while it holds req_lock; otherwise req_lock is unused.
// Ports:
//   clk, reset (async, active low)
//   req_valid/req_data/req_lock  per-requester byte offer and lock request
//   req_ready                    one-cycle accept pulse per requester
//   uart_start/uart_data_tx      start pulse and held byte to the UART
//   uart_busy                    UART transmitting
//   owner                        last granted requester
//   arb_busy                     arbiter not idle (decoded from state)
//   timeout_err                  sticky start-not-acknowledged flag
module mini16_uart_tx_arbiter
  import mini16_uart_arb_pkg::*;
#(
  parameter int  CORES        = 4,
  parameter int  WIDTH        = 8,
  parameter int  BUSY_TIMEOUT = 16,
  localparam int IDX_W        = clog2_min1(CORES)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [CORES-1:0]       req_valid,
  input  logic [CORES*WIDTH-1:0] req_data,
  input  logic [CORES-1:0]       req_lock,
  output logic [CORES-1:0]       req_ready,
  output logic                   uart_start,
  output logic [WIDTH-1:0]       uart_data_tx,
  input  logic                   uart_busy,
  output logic [IDX_W-1:0]       owner,
  output logic                   arb_busy,
  output logic                   timeout_err
);

  localparam int               CNT_W    = clog2_min1(BUSY_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

  // Explicit compare so a non-power-of-two CORES wraps at CORES-1.
  function automatic logic [IDX_W-1:0] f_next_idx(input logic [IDX_W-1:0] i_idx);
    if (int'(i_idx) == CORES - 1) return '0;
    return i_idx + IDX_W'(1);
  endfunction

  arb_state_t         r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_ptr, r_owner;
  logic [CNT_W-1:0]   r_cnt;
  logic [CORES-1:0]   r_req_ready;
  logic               r_uart_start;
  logic [WIDTH-1:0]   r_data;
  logic               r_timeout_err;

  logic [CORES-1:0]   w_pick_req;
  logic [IDX_W-1:0]   w_pick_ptr, w_ptr_after, w_winner;
  logic               w_found, w_grant, w_fire, w_timeout, w_done;

`ifdef UART_ARB_LOCK_EN
  logic               r_locked;
  logic [CORES-1:0]   w_owner_mask;

  assign w_owner_mask = {{(CORES-1){1'b0}}, 1'b1} << r_owner;
  // While the lock is held only the owner may win; once it drops, the search
  // starts just past the owner as if the lock had never been taken.
  assign w_pick_req  = (r_locked && req_lock[r_owner]) ? (req_valid & w_owner_mask) : req_valid;
  assign w_pick_ptr  = (r_locked && !req_lock[r_owner]) ? f_next_idx(r_owner) : r_ptr;
  assign w_ptr_after = req_lock[r_owner] ? r_owner : f_next_idx(r_owner);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       r_locked <= 1'b0;
    else if (w_done)  r_locked <= req_lock[r_owner];
    else if (w_grant) r_locked <= 1'b0;
  end
`else
  logic w_unused_lock;

  assign w_unused_lock = ^req_lock;
  assign w_pick_req    = req_valid;
  assign w_pick_ptr    = r_ptr;
  assign w_ptr_after   = f_next_idx(r_owner);
`endif

  mini16_rr_pick #(
    .N  (CORES),
    .PW (IDX_W)
  ) u_pick (
    .i_req    (w_pick_req),
    .i_ptr    (w_pick_ptr),
    .o_winner (w_winner),
    .o_found  (w_found)
  );

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:      if (w_found) w_state_nxt = ST_START;
      ST_START:     w_state_nxt = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (uart_busy)              w_state_nxt = ST_WAIT_DONE;
        else if (r_cnt == CNT_LAST) w_state_nxt = ST_IDLE;
      end
      ST_WAIT_DONE: if (!uart_busy) w_state_nxt = ST_IDLE;
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode: per-state events that drive the registered datapath.
  always_comb begin
    w_grant   = 1'b0;
    w_fire    = 1'b0;
    w_timeout = 1'b0;
    w_done    = 1'b0;
    unique case (r_state)
      ST_IDLE:      w_grant   = w_found;
      ST_START:     w_fire    = 1'b1;
      ST_WAIT_BUSY: w_timeout = !uart_busy && (r_cnt == CNT_LAST);
      ST_WAIT_DONE: w_done    = !uart_busy;
      default:      ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr         <= '0;
      r_owner       <= '0;
      r_cnt         <= '0;
      r_req_ready   <= '0;
      r_uart_start  <= 1'b0;
      r_data        <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_req_ready  <= '0;
      r_uart_start <= w_fire;
      if (w_grant) begin
        r_req_ready <= {{(CORES-1){1'b0}}, 1'b1} << w_winner;
        r_data      <= req_data[int'(w_winner)*WIDTH +: WIDTH];
        r_owner     <= w_winner;
      end
      if (w_fire)                         r_cnt <= '0;
      else if (r_state == ST_WAIT_BUSY)   r_cnt <= r_cnt + CNT_W'(1);
      if (w_timeout) r_timeout_err <= 1'b1;
      // A timed-out byte leaves ptr alone; only a completed byte advances it.
      if (w_done)    r_ptr <= w_ptr_after;
    end
  end

  assign req_ready    = r_req_ready;
  assign uart_start   = r_uart_start;
  assign uart_data_tx = r_data;
  assign owner        = r_owner;
  assign timeout_err  = r_timeout_err;
  assign arb_busy     = (r_state != ST_IDLE);

endmodule
